// File: rtl/pe_ws_dbuf_if.sv
// Bundle of the control, data, weight and partial-sum signals around one
// weight-stationary PE.
interface pe_ws_dbuf_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 20
);
    logic [1:0]              mode;
    logic                    swap;
    logic                    clr_ovf;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    data_in_valid;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    data_out_valid;
    logic [WEIGHT_WIDTH-1:0] wgt_in;
    logic [WEIGHT_WIDTH-1:0] wgt_out;
    logic [ACC_WIDTH-1:0]    psum_in;
    logic                    psum_in_valid;
    logic [ACC_WIDTH-1:0]    psum_out;
    logic                    psum_out_valid;
    logic                    shadow_full;
    logic                    ovf;

    modport master (
        output mode, swap, clr_ovf, data_in, data_in_valid, wgt_in, psum_in, psum_in_valid,
        input  data_out, data_out_valid, wgt_out, psum_out, psum_out_valid, shadow_full, ovf
    );

    modport slave (
        input  mode, swap, clr_ovf, data_in, data_in_valid, wgt_in, psum_in, psum_in_valid,
        output data_out, data_out_valid, wgt_out, psum_out, psum_out_valid, shadow_full, ovf
    );
endinterface

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary MAC processing element with a double-buffered weight:
// a shadow register shifts in new weights while the active one feeds the MAC.
module pe_ws_dbuf #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 20,
    parameter int SATURATE     = 1
) (
    input logic        clk,
    input logic        rst,
    pe_ws_dbuf_if.slave bus
);
    localparam int ProdWidth = DATA_WIDTH + WEIGHT_WIDTH;

    logic [WEIGHT_WIDTH-1:0]        shadow_q, shadow_d;
    logic signed [WEIGHT_WIDTH-1:0] active_q, active_d;
    logic                           shadow_full_q, shadow_full_d;
    logic [DATA_WIDTH-1:0]          data_out_q, data_out_d;
    logic                           data_out_valid_q, data_out_valid_d;
    logic [ACC_WIDTH-1:0]           psum_out_q, psum_out_d;
    logic                           psum_out_valid_q, psum_out_valid_d;
    logic                           ovf_q, ovf_d;

    logic                    load, fire, do_swap;
    logic signed [ProdWidth-1:0] prod;
    logic [ACC_WIDTH:0]      prod_ext, addend, sum;
    logic                    sum_ovf;
    logic [ACC_WIDTH-1:0]    result;
    logic [ACC_WIDTH-1:0]    sat_max, sat_min;

    assign load    = bus.mode[0];
    assign fire    = bus.mode[1] & bus.data_in_valid;
    assign do_swap = bus.swap & shadow_full_q;

    assign sat_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign sat_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // One guard bit above ACC_WIDTH: overflow shows as the top two bits disagreeing.
    assign prod     = $signed(bus.data_in) * active_q;
    assign prod_ext = {{(ACC_WIDTH+1-ProdWidth){prod[ProdWidth-1]}}, prod};
    assign addend   = bus.psum_in_valid ? {bus.psum_in[ACC_WIDTH-1], bus.psum_in} : '0;
    assign sum      = prod_ext + addend;
    assign sum_ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

    always_comb begin
        result = sum[ACC_WIDTH-1:0];
        if (SATURATE != 0 && sum_ovf) begin
            result = sum[ACC_WIDTH] ? sat_min : sat_max;
        end
    end

    always_comb begin
        shadow_d         = shadow_q;
        active_d         = active_q;
        shadow_full_d    = shadow_full_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        psum_out_d       = psum_out_q;
        psum_out_valid_d = 1'b0;
        ovf_d            = ovf_q & ~bus.clr_ovf;

        // Swap reads the pre-edge shadow, so a simultaneous load is safe.
        if (do_swap) begin
            active_d      = $signed(shadow_q);
            shadow_full_d = 1'b0;
        end
        if (load) begin
            shadow_d      = bus.wgt_in;
            shadow_full_d = 1'b1;
        end
        if (fire) begin
            data_out_d       = bus.data_in;
            data_out_valid_d = 1'b1;
            psum_out_d       = result;
            psum_out_valid_d = 1'b1;
            if (sum_ovf) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q         <= '0;
            active_q         <= '0;
            shadow_full_q    <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            psum_out_q       <= '0;
            psum_out_valid_q <= 1'b0;
            ovf_q            <= 1'b0;
        end else begin
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            shadow_full_q    <= shadow_full_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            psum_out_q       <= psum_out_d;
            psum_out_valid_q <= psum_out_valid_d;
            ovf_q            <= ovf_d;
        end
    end

    assign bus.wgt_out        = shadow_q;
    assign bus.shadow_full    = shadow_full_q;
    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;
    assign bus.psum_out       = psum_out_q;
    assign bus.psum_out_valid = psum_out_valid_q;
    assign bus.ovf            = ovf_q;
endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Scoreboard bench for pe_ws_dbuf: a saturating 16-bit PE plus a 4-PE wrapping weight chain.
module tb_pe_ws_dbuf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] psum;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    pe_ws_dbuf_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(16)) m ();
    pe_ws_dbuf #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .bus(m)
    );

    logic [1:0]  ch_mode;
    logic        ch_swap, ch_clr, ch_dv, ch_pv;
    logic [7:0]  ch_din;
    logic [15:0] ch_pin;
    logic [7:0]  ch_w [5];
    logic [15:0] ch_pout [4];
    logic [3:0]  ch_full, ch_ovf;

    for (genvar g = 0; g < 4; g++) begin : g_chain
        pe_ws_dbuf_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(16)) cif ();
        assign cif.mode          = ch_mode;
        assign cif.swap          = ch_swap;
        assign cif.clr_ovf       = ch_clr;
        assign cif.data_in       = ch_din;
        assign cif.data_in_valid = ch_dv;
        assign cif.psum_in       = ch_pin;
        assign cif.psum_in_valid = ch_pv;
        assign cif.wgt_in        = ch_w[g];
        assign ch_w[g+1]         = cif.wgt_out;
        assign ch_pout[g]        = cif.psum_out;
        assign ch_full[g]        = cif.shadow_full;
        assign ch_ovf[g]         = cif.ovf;
        pe_ws_dbuf #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)) u_pe (
            .clk(clk), .rst(rst), .bus(cif)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m.mode = 2'b00; m.swap = 1'b0; m.clr_ovf = 1'b0;
        m.data_in = '0; m.data_in_valid = 1'b0; m.wgt_in = '0;
        m.psum_in = '0; m.psum_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        ch_mode = 2'b00; ch_swap = 1'b0; ch_clr = 1'b0; ch_dv = 1'b0; ch_pv = 1'b0;
        ch_din = '0; ch_pin = '0; ch_w[0] = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (m.psum_out !== 16'h0) $display("FAIL rst_psum got %h want 0", m.psum_out); else n_pass++;
        n_checks++; if (m.psum_out_valid !== 1'b0) $display("FAIL rst_pvalid got %b want 0", m.psum_out_valid); else n_pass++;
        n_checks++; if (m.data_out !== 8'h0) $display("FAIL rst_data got %h want 0", m.data_out); else n_pass++;
        n_checks++; if (m.data_out_valid !== 1'b0) $display("FAIL rst_dvalid got %b want 0", m.data_out_valid); else n_pass++;
        n_checks++; if (m.shadow_full !== 1'b0) $display("FAIL rst_full got %b want 0", m.shadow_full); else n_pass++;
        n_checks++; if (m.ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", m.ovf); else n_pass++;
        n_checks++; if (m.wgt_out !== 8'h0) $display("FAIL rst_wgt got %h want 0", m.wgt_out); else n_pass++;
    endtask

    task automatic test_basic();
        m.mode = 2'b01; m.wgt_in = 8'sd5;
        tick();
        idle();
        n_checks++; if (m.shadow_full !== 1'b1) $display("FAIL load_full got %b want 1", m.shadow_full); else n_pass++;
        n_checks++; if (m.wgt_out !== 8'd5) $display("FAIL load_wgt got %0d want 5", m.wgt_out); else n_pass++;
        m.swap = 1'b1;
        tick();
        idle();
        n_checks++; if (m.shadow_full !== 1'b0) $display("FAIL swap_full got %b want 0", m.shadow_full); else n_pass++;
        m.mode = 2'b10; m.data_in = 8'sd3; m.data_in_valid = 1'b1;
        m.psum_in = 16'sd10; m.psum_in_valid = 1'b1;
        sb.push_back('{data: 8'd3, psum: 16'sd25});
        tick();
        idle();
        e = sb.pop_front();
        n_checks++; if (m.psum_out_valid !== 1'b1) $display("FAIL basic_pvalid got %b want 1", m.psum_out_valid); else n_pass++;
        n_checks++; if (m.psum_out !== e.psum) $display("FAIL basic_psum got %0d want %0d", $signed(m.psum_out), $signed(e.psum)); else n_pass++;
        n_checks++; if (m.data_out !== e.data) $display("FAIL basic_data got %0d want %0d", m.data_out, e.data); else n_pass++;
        n_checks++; if (m.data_out_valid !== 1'b1) $display("FAIL basic_dvalid got %b want 1", m.data_out_valid); else n_pass++;
    endtask

    task automatic test_hold();
        // Active is 5 and the shadow is empty: swap must not disturb anything.
        m.swap = 1'b1;
        tick();
        idle();
        n_checks++; if (m.shadow_full !== 1'b0) $display("FAIL nswap_full got %b want 0", m.shadow_full); else n_pass++;
        m.mode = 2'b10; m.data_in = 8'sd2; m.data_in_valid = 1'b1; m.psum_in = 16'sd7;
        sb.push_back('{data: 8'd2, psum: 16'sd10});
        tick();
        idle();
        e = sb.pop_front();
        n_checks++; if (m.psum_out_valid !== 1'b1 || m.psum_out !== e.psum) $display("FAIL nswap_psum got %0d/%b want %0d/1", $signed(m.psum_out), m.psum_out_valid, $signed(e.psum)); else n_pass++;
        m.mode = 2'b10; m.data_in = 8'sd9; m.data_in_valid = 1'b0; m.psum_in = 16'sd50; m.psum_in_valid = 1'b1;
        tick();
        n_checks++; if (m.psum_out_valid !== 1'b0 || m.data_out_valid !== 1'b0) $display("FAIL novalid_valids got %b%b want 00", m.psum_out_valid, m.data_out_valid); else n_pass++;
        n_checks++; if (m.psum_out !== 16'sd10) $display("FAIL novalid_psum got %0d want 10", $signed(m.psum_out)); else n_pass++;
        n_checks++; if (m.data_out !== 8'd2) $display("FAIL novalid_data got %0d want 2", m.data_out); else n_pass++;
        m.mode = 2'b00; m.data_in_valid = 1'b1;
        tick();
        idle();
        n_checks++; if (m.psum_out_valid !== 1'b0 || m.psum_out !== 16'sd10) $display("FAIL idle_hold got %0d/%b want 10/0", $signed(m.psum_out), m.psum_out_valid); else n_pass++;
    endtask

    task automatic test_swap_fire();
        m.mode = 2'b01; m.wgt_in = -8'sd2;
        tick();
        idle(); m.swap = 1'b1;
        tick();
        idle(); m.mode = 2'b01; m.wgt_in = 8'sd7;
        tick();
        idle();
        m.mode = 2'b10; m.swap = 1'b1; m.data_in = 8'sd4; m.data_in_valid = 1'b1;
        sb.push_back('{data: 8'd4, psum: -16'sd8});
        tick();
        idle();
        e = sb.pop_front();
        n_checks++; if (m.psum_out_valid !== 1'b1 || m.psum_out !== e.psum) $display("FAIL swapfire_psum got %0d/%b want %0d/1", $signed(m.psum_out), m.psum_out_valid, $signed(e.psum)); else n_pass++;
        n_checks++; if (m.shadow_full !== 1'b0) $display("FAIL swapfire_full got %b want 0", m.shadow_full); else n_pass++;
        m.mode = 2'b10; m.data_in = 8'sd4; m.data_in_valid = 1'b1; m.psum_in = 16'sd100;
        sb.push_back('{data: 8'd4, psum: 16'sd28});
        tick();
        idle();
        e = sb.pop_front();
        n_checks++; if (m.psum_out_valid !== 1'b1 || m.psum_out !== e.psum) $display("FAIL nopsum_psum got %0d/%b want %0d/1", $signed(m.psum_out), m.psum_out_valid, $signed(e.psum)); else n_pass++;
        // Swap and load together: active takes old shadow (3), shadow takes 6.
        m.mode = 2'b01; m.wgt_in = 8'sd3;
        tick();
        idle();
        m.mode = 2'b11; m.wgt_in = 8'sd6; m.swap = 1'b1; m.data_in = 8'sd1; m.data_in_valid = 1'b1;
        sb.push_back('{data: 8'd1, psum: 16'sd7});
        tick();
        idle();
        e = sb.pop_front();
        n_checks++; if (m.psum_out !== e.psum) $display("FAIL swapload_psum got %0d want %0d", $signed(m.psum_out), $signed(e.psum)); else n_pass++;
        n_checks++; if (m.shadow_full !== 1'b1 || m.wgt_out !== 8'd6) $display("FAIL swapload_shadow got %0d/%b want 6/1", m.wgt_out, m.shadow_full); else n_pass++;
        m.mode = 2'b10; m.data_in = 8'sd1; m.data_in_valid = 1'b1;
        sb.push_back('{data: 8'd1, psum: 16'sd3});
        tick();
        idle();
        e = sb.pop_front();
        n_checks++; if (m.psum_out !== e.psum) $display("FAIL swapload_active got %0d want %0d", $signed(m.psum_out), $signed(e.psum)); else n_pass++;
    endtask

    task automatic test_sat();
        m.mode = 2'b01; m.wgt_in = 8'sd127;
        tick();
        idle(); m.swap = 1'b1;
        tick();
        idle();
        n_checks++; if (m.ovf !== 1'b0) $display("FAIL sat_pre_ovf got %b want 0", m.ovf); else n_pass++;
        m.mode = 2'b10; m.data_in = 8'sd127; m.data_in_valid = 1'b1;
        m.psum_in = 16'sd32700; m.psum_in_valid = 1'b1;
        sb.push_back('{data: 8'd127, psum: 16'h7fff});
        tick();
        idle();
        e = sb.pop_front();
        n_checks++; if (m.psum_out !== e.psum) $display("FAIL sat_pos got %0d want %0d", $signed(m.psum_out), $signed(e.psum)); else n_pass++;
        n_checks++; if (m.ovf !== 1'b1) $display("FAIL sat_ovf got %b want 1", m.ovf); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (m.ovf !== 1'b1) $display("FAIL sat_sticky got %b want 1", m.ovf); else n_pass++;
        m.clr_ovf = 1'b1;
        tick();
        idle();
        n_checks++; if (m.ovf !== 1'b0) $display("FAIL sat_clr got %b want 0", m.ovf); else n_pass++;
        m.mode = 2'b10; m.data_in = -8'sd128; m.data_in_valid = 1'b1; m.clr_ovf = 1'b1;
        m.psum_in = -16'sd32000; m.psum_in_valid = 1'b1;
        sb.push_back('{data: 8'h80, psum: 16'h8000});
        tick();
        idle();
        e = sb.pop_front();
        n_checks++; if (m.psum_out !== e.psum) $display("FAIL sat_neg got %0d want %0d", $signed(m.psum_out), $signed(e.psum)); else n_pass++;
        n_checks++; if (m.ovf !== 1'b1) $display("FAIL sat_setwins got %b want 1", m.ovf); else n_pass++;
        m.clr_ovf = 1'b1;
        tick();
        idle();
        n_checks++; if (m.ovf !== 1'b0) $display("FAIL sat_clr2 got %b want 0", m.ovf); else n_pass++;
    endtask

    task automatic test_rst_mid();
        m.mode = 2'b11; m.wgt_in = 8'sd9; m.swap = 1'b1; m.data_in = 8'sd127; m.data_in_valid = 1'b1;
        m.psum_in = 16'sd32700; m.psum_in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        n_checks++; if (m.psum_out !== 16'h0 || m.psum_out_valid !== 1'b0) $display("FAIL rstmid_psum got %h/%b want 0/0", m.psum_out, m.psum_out_valid); else n_pass++;
        n_checks++; if (m.data_out !== 8'h0 || m.data_out_valid !== 1'b0) $display("FAIL rstmid_data got %h/%b want 0/0", m.data_out, m.data_out_valid); else n_pass++;
        n_checks++; if (m.shadow_full !== 1'b0 || m.ovf !== 1'b0) $display("FAIL rstmid_flags got %b%b want 00", m.shadow_full, m.ovf); else n_pass++;
        m.mode = 2'b10; m.data_in = 8'sd9; m.data_in_valid = 1'b1;
        sb.push_back('{data: 8'd9, psum: 16'sd0});
        tick();
        idle();
        if (sb.size() != 0 && m.psum_out_valid !== 1'b1) begin
            n_checks++; $display("FAIL rstmid_nooutput got %b want 1", m.psum_out_valid);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            n_checks++; if (m.psum_out !== e.psum || m.data_out !== e.data) $display("FAIL rstmid_fire got %0d want %0d", $signed(m.psum_out), $signed(e.psum)); else n_pass++;
        end
    endtask

    task automatic test_chain();
        logic [7:0] w [4];
        w[0] = 8'sd11; w[1] = -8'sd22; w[2] = 8'sd33; w[3] = -8'sd44;
        n_checks++; if (ch_w[4] !== 8'h0 || ch_full !== 4'h0) $display("FAIL chain_rst got %h/%b want 0/0000", ch_w[4], ch_full); else n_pass++;
        ch_mode = 2'b01;
        for (int i = 3; i >= 0; i--) begin
            ch_w[0] = w[i];
            tick();
        end
        ch_mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (ch_w[i+1] !== w[i]) $display("FAIL chain_w%0d got %0d want %0d", i, $signed(ch_w[i+1]), $signed(w[i])); else n_pass++;
        end
        n_checks++; if (ch_full !== 4'hf) $display("FAIL chain_full got %b want 1111", ch_full); else n_pass++;
        ch_mode = 2'b01; ch_w[0] = 8'sd127;
        tick();
        ch_mode = 2'b00; ch_swap = 1'b1;
        tick();
        ch_swap = 1'b0;
        ch_mode = 2'b10; ch_din = 8'sd127; ch_dv = 1'b1; ch_pin = 16'sd32700; ch_pv = 1'b1;
        tick();
        ch_mode = 2'b00; ch_dv = 1'b0; ch_pv = 1'b0;
        n_checks++; if (ch_pout[0] !== -16'sd16707) $display("FAIL wrap_psum got %0d want -16707", $signed(ch_pout[0])); else n_pass++;
        n_checks++; if (ch_ovf[0] !== 1'b1) $display("FAIL wrap_ovf got %b want 1", ch_ovf[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_swap_fire();
        test_sat();
        test_rst_mid();
        test_chain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pe_ws_dbuf.md
PE_WS_DBUF -- requirements
Module: pe_ws_dbuf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed activation width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8: signed weight width.
REQ-003 SHALL have parameter ACC_WIDTH, default 20: signed partial-sum width; must be >= DATA_WIDTH+WEIGHT_WIDTH.
REQ-004 SHALL have parameter SATURATE, default 1: 1 = clamp accumulate result, 0 = two's-complement wrap.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port mode  input  2  00 idle, 01 load shadow, 10 compute, 11 compute plus load shadow.
REQ-008 SHALL have port swap  input  1  single-cycle request to copy the shadow weight into the active weight.
REQ-009 SHALL have port clr_ovf  input  1  clears the overflow sticky flag.
REQ-010 SHALL have ports data_in, data_in_valid  input  DATA_WIDTH, 1  horizontal activation and its qualifier.
REQ-011 SHALL have ports data_out, data_out_valid  output  DATA_WIDTH, 1  registered horizontal forward.
REQ-012 SHALL have ports wgt_in, wgt_out  input/output  WEIGHT_WIDTH  vertical weight shift chain; wgt_out = shadow register.
REQ-013 SHALL have ports psum_in, psum_in_valid  input  ACC_WIDTH, 1  vertical partial sum and its qualifier.
REQ-014 SHALL have ports psum_out, psum_out_valid  output  ACC_WIDTH, 1  registered vertical partial sum.
REQ-015 SHALL have port shadow_full  output  1  shadow weight loaded and not yet swapped.
REQ-016 SHALL have port ovf  output  1  sticky saturation/overflow indicator.

Function
REQ-017 Load: when mode[0]=1, SHALL capture shadow <= wgt_in on each clock and set shadow_full=1; wgt_out updates one cycle later (one-stage shift per PE).
REQ-018 Swap: when swap=1 and shadow_full=1, SHALL copy active <= shadow at the clock edge and clear shadow_full; when shadow_full=0, swap SHALL be ignored.
REQ-019 Swap together with load in the same cycle: active SHALL receive the pre-edge shadow value, shadow SHALL take wgt_in, and shadow_full SHALL remain 1.
REQ-020 Compute fires when mode[1]=1 and data_in_valid=1; the MAC SHALL use the pre-edge active weight, including in a cycle where swap is also asserted.
REQ-021 On fire: data_out <= data_in; data_out_valid <= 1; psum_out <= f(p + data_in*active), with p = psum_in if psum_in_valid else 0; psum_out_valid <= 1. Latency is 1 cycle.
REQ-022 On any non-fire cycle: data_out_valid and psum_out_valid SHALL be 0, and data_out and psum_out SHALL hold their values.
REQ-023 Arithmetic SHALL use signed operands; the product SHALL be sign-extended to ACC_WIDTH+1 before the add.
REQ-024 SATURATE=1: results above 2^(ACC_WIDTH-1)-1 or below -2^(ACC_WIDTH-1) SHALL clamp to that limit and set ovf.
REQ-025 SATURATE=0: results SHALL wrap modulo 2^ACC_WIDTH and set ovf on signed overflow.
REQ-026 ovf SHALL be sticky until clr_ovf=1 or reset; a set and a clear in the same cycle: the set SHALL win.
REQ-027 mode=00 SHALL freeze all state except the swap and clr_ovf effects.

Reset
REQ-028 While rst=1 at a clock edge: shadow, active, data_out, psum_out SHALL be 0, and shadow_full, data_out_valid, psum_out_valid, ovf SHALL be 0.
REQ-029 rst SHALL take priority over every other input, including mid-load and mid-compute; the first post-reset fire SHALL use active=0.

Verification
REQ-030 Bench SHALL cover: load wgt_in=5, then swap, then compute data_in=3, psum_in=10 valid -> next cycle psum_out=25, psum_out_valid=1, data_out=3.
REQ-031 Bench SHALL cover: active=-2, load shadow=7, and fire data_in=4 with swap in the same cycle -> psum_out=-8; next fire data_in=4 with psum_in_valid=0 -> psum_out=28.
REQ-032 Bench SHALL cover: SATURATE=1, ACC_WIDTH=16, active=127, data_in=127, psum_in=32700 -> psum_out=32767 and ovf=1; ovf stays 1 until clr_ovf is asserted.
REQ-033 Bench SHALL cover: swap with shadow_full=0 -> active unchanged; mode=10 with data_in_valid=0 -> both valids 0 and outputs held.
REQ-034 Bench SHALL cover: rst=1 during compute with mode=11 -> all outputs 0 on the next edge, and shadow_full=0.
REQ-035 Bench SHALL cover: a 4-PE chain loading 4 weights over 4 cycles -> each PE shadow holds the correct weight after cycle 4.
